jesd207_burst_ctrl: RTL and testbench

Burst sequencer for the JESD207 FIFO datapath. It drives the TXNRX/ENABLE pair toward the RF transceiver and the FIFO read/write enables. On a start request it applies JESD207 setup, hold and guard spacing. It ends bursts on a beat count, a stop request, or a FIFO boundary. It sits between the user control (proc_start, btn_tx_nrx) and the FIFO/PHY top.

---
 rtl/jesd207_ctrl_pkg.sv | 31 +++
 rtl/jesd207_burst_ctrl_if.sv | 32 +++
 rtl/jesd207_gap_timer.sv | 26 ++
 rtl/jesd207_burst_ctrl.sv | 141 ++++++++++++++
 tb/tb_jesd207_burst_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/jesd207_ctrl_pkg.sv
// rtl/jesd207_ctrl_pkg.sv - shared types and helpers for the JESD207 burst sequencer
// Contents: sequencer state enum, direction constants, burst exit-cause enum,
// and a max helper used to size the shared gap timer.
package jesd207_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_WAIT_FIFO = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_HOLD      = 3'd4,
        ST_GUARD     = 3'd5
    } state_e;

    localparam logic DIR_TX = 1'b1;
    localparam logic DIR_RX = 1'b0;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_COUNT    = 2'd1,
        CAUSE_STOP     = 2'd2,
        CAUSE_BOUNDARY = 2'd3
    } cause_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jesd207_burst_ctrl_if.sv
// rtl/jesd207_burst_ctrl_if.sv - control/status bundle between user/FIFO side and the burst sequencer
// Modports: master = user/FIFO side (drives requests and FIFO flags),
//           slave  = sequencer (drives TXNRX/ENABLE, FIFO strobes and status).
interface jesd207_burst_ctrl_if #(
    parameter int BURST_W = 16
);
    logic               proc_start;
    logic               proc_stop;
    logic               btn_tx_nrx;
    logic [BURST_W-1:0] burst_len;
    logic               prog_full;
    logic               rempty;
    logic               wfull;
    logic               tx_nrx;
    logic               jesd_en;
    logic               fifo_rd_en;
    logic               fifo_wr_en;
    logic               busy;
    logic               done;
    logic               err;
    logic [BURST_W-1:0] beat_cnt;

    modport master (
        output proc_start, proc_stop, btn_tx_nrx, burst_len, prog_full, rempty, wfull,
        input  tx_nrx, jesd_en, fifo_rd_en, fifo_wr_en, busy, done, err, beat_cnt
    );

    modport slave (
        input  proc_start, proc_stop, btn_tx_nrx, burst_len, prog_full, rempty, wfull,
        output tx_nrx, jesd_en, fifo_rd_en, fifo_wr_en, busy, done, err, beat_cnt
    );
endinterface

// File: rtl/jesd207_gap_timer.sv
// rtl/jesd207_gap_timer.sv - loadable down-counter timing the SETUP/HOLD/GUARD gaps
// Ports: mclk, rstn (sync active-low), load_i/load_val_i (load N-1 for an N-cycle gap),
//        zero_o (count has reached 0, i.e. the last cycle of the gap).
module jesd207_gap_timer #(
    parameter int W = 3
) (
    input  logic         mclk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge mclk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/jesd207_burst_ctrl.sv
// rtl/jesd207_burst_ctrl.sv - JESD207 burst sequencer driving TXNRX/ENABLE and FIFO strobes
// Ports: mclk, rstn (sync active-low), bus (jesd207_burst_ctrl_if.slave): requests
//        proc_start/proc_stop/btn_tx_nrx/burst_len, FIFO flags prog_full/rempty/wfull;
//        registered outputs tx_nrx, jesd_en, fifo_rd_en, fifo_wr_en, busy, done, err, beat_cnt.
// Option: JESD207_PULSE_MODE_EN selects pulse-mode ENABLE (default level mode).
module jesd207_burst_ctrl
    import jesd207_ctrl_pkg::*;
#(
    parameter int BURST_W   = 16,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GUARD_CYC = 4
) (
    input  logic mclk,
    input  logic rstn,
    jesd207_burst_ctrl_if.slave bus
);
    localparam int TW = $clog2(max3(SETUP_CYC, HOLD_CYC, GUARD_CYC) + 1);

    state_e             state_q, state_d;
    cause_e             cause;
    logic               dir_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] beat_cnt_q;
    logic               tx_nrx_q, jesd_en_q, rd_en_q, wr_en_q;
    logic               busy_q, done_q, err_q;
    logic               last_beat, boundary;
    logic               timer_load, timer_zero;
    logic [TW-1:0]      timer_val;

    jesd207_gap_timer #(.W(TW)) u_gap_timer (
        .mclk       (mclk),
        .rstn       (rstn),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Transition decode; the registered state and all outputs live in the always_ff below.
    always_comb begin
        state_d   = state_q;
        cause     = CAUSE_NONE;
        last_beat = (len_q != '0) && (beat_cnt_q == len_q - BURST_W'(1));
        boundary  = (dir_q == DIR_TX) ? bus.rempty : bus.wfull;
        case (state_q)
            ST_IDLE: begin
                if (bus.proc_start && !bus.proc_stop) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (bus.proc_stop) begin
                    state_d = ST_GUARD;
                end else if (timer_zero) begin
                    // A TX FIFO already pre-filled skips WAIT_FIFO entirely.
                    if (dir_q == DIR_TX && !bus.prog_full) state_d = ST_WAIT_FIFO;
                    else                                   state_d = ST_ACTIVE;
                end
            end
            ST_WAIT_FIFO: begin
                if (bus.proc_stop)      state_d = ST_GUARD;
                else if (bus.prog_full) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // The count exit beats a simultaneous FIFO boundary (no error).
                if (last_beat)          cause = CAUSE_COUNT;
                else if (boundary)      cause = CAUSE_BOUNDARY;
                else if (bus.proc_stop) cause = CAUSE_STOP;
                if (cause != CAUSE_NONE) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (timer_zero) state_d = ST_GUARD;
            end
            ST_GUARD: begin
                if (timer_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reloading on every transition is harmless for untimed states.
        timer_load = (state_d != state_q);
        case (state_d)
            ST_SETUP: timer_val = TW'(SETUP_CYC - 1);
            ST_HOLD:  timer_val = TW'(HOLD_CYC - 1);
            ST_GUARD: timer_val = TW'(GUARD_CYC - 1);
            default:  timer_val = '0;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RX;
            len_q      <= '0;
            beat_cnt_q <= '0;
            tx_nrx_q   <= 1'b0;
            jesd_en_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_q == ST_GUARD) && (state_d == ST_IDLE);
            rd_en_q <= (state_d == ST_ACTIVE) && (dir_q == DIR_TX);
            wr_en_q <= (state_d == ST_ACTIVE) && (dir_q == DIR_RX);
`ifdef JESD207_PULSE_MODE_EN
            jesd_en_q <= ((state_d == ST_ACTIVE) && (state_q != ST_ACTIVE)) ||
                         ((state_d == ST_HOLD)   && (state_q == ST_ACTIVE));
`else
            jesd_en_q <= (state_d == ST_ACTIVE);
`endif
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_SETUP) begin
                        dir_q      <= bus.btn_tx_nrx;
                        len_q      <= bus.burst_len;
                        tx_nrx_q   <= bus.btn_tx_nrx;
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // An underrun/overflow beat is not counted; every other beat is.
                    if (cause == CAUSE_BOUNDARY) err_q <= 1'b1;
                    else                         beat_cnt_q <= beat_cnt_q + BURST_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_nrx     = tx_nrx_q;
    assign bus.jesd_en    = jesd_en_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.beat_cnt   = beat_cnt_q;
endmodule

// File: tb/tb_jesd207_burst_ctrl.sv
// tb/tb_jesd207_burst_ctrl.sv - directed self-checking bench for jesd207_burst_ctrl
module tb_jesd207_burst_ctrl;
    logic mclk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 mclk = ~mclk;

    jesd207_burst_ctrl_if #(.BURST_W(16)) bus ();

    jesd207_burst_ctrl #(
        .BURST_W(16), .SETUP_CYC(2), .HOLD_CYC(2), .GUARD_CYC(4)
    ) dut (
        .mclk (mclk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Expected ENABLE for a burst whose ACTIVE window spans cycles first..last.
    function automatic logic exp_en(input int c, input int first, input int last);
`ifdef JESD207_PULSE_MODE_EN
        return (c == first) || (c == last + 1);
`else
        return (c >= first) && (c <= last);
`endif
    endfunction

    task automatic start_burst(input logic dir, input logic [15:0] len);
        bus.btn_tx_nrx = dir;
        bus.burst_len  = len;
        bus.proc_start = 1'b1;
        tick();
        bus.proc_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.proc_start = 0; bus.proc_stop = 0; bus.btn_tx_nrx = 0; bus.burst_len = '0;
        bus.prog_full = 0;  bus.rempty = 0;    bus.wfull = 0;
        repeat (3) tick();
        chk("rst_tx_nrx", 32'(bus.tx_nrx), 0);
        chk("rst_jesd_en", 32'(bus.jesd_en), 0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_beat_cnt", 32'(bus.beat_cnt), 0);
        rstn = 1'b1;
        tick();

        // 1: TX, len 8, pre-filled FIFO
        bus.prog_full = 1'b1;
        start_burst(1'b1, 16'd8);
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) tick();
            chk("t1_tx_nrx", 32'(bus.tx_nrx), 1);
            chk("t1_jesd_en", 32'(bus.jesd_en), 32'(exp_en(c, 3, 10)));
            chk("t1_rd_en", 32'(bus.fifo_rd_en), 32'(c >= 3 && c <= 10));
            chk("t1_wr_en", 32'(bus.fifo_wr_en), 0);
            chk("t1_busy", 32'(bus.busy), 32'(c <= 16));
            chk("t1_done", 32'(bus.done), 32'(c == 17));
        end
        chk("t1_beat_cnt", 32'(bus.beat_cnt), 8);
        chk("t1_err", 32'(bus.err), 0);

        // 2: TX, len 4, prog_full arrives late
        bus.prog_full = 1'b0;
        start_burst(1'b1, 16'd4);
        for (int c = 1; c <= 31; c++) begin
            if (c > 1) tick();
            chk("t2_jesd_en", 32'(bus.jesd_en), 32'(exp_en(c, 26, 29)));
            chk("t2_rd_en", 32'(bus.fifo_rd_en), 32'(c >= 26 && c <= 29));
            chk("t2_busy", 32'(bus.busy), 1);
            if (c == 25) bus.prog_full = 1'b1;
        end
        wait_done("t2_done");
        chk("t2_beat_cnt", 32'(bus.beat_cnt), 4);

        // 3: RX, unbounded, stop in the 6th ACTIVE cycle
        start_burst(1'b0, 16'd0);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) tick();
            chk("t3_tx_nrx", 32'(bus.tx_nrx), 0);
            chk("t3_jesd_en", 32'(bus.jesd_en), 32'(exp_en(c, 3, 8)));
            chk("t3_wr_en", 32'(bus.fifo_wr_en), 32'(c >= 3 && c <= 8));
            chk("t3_rd_en", 32'(bus.fifo_rd_en), 0);
            if (c == 8) bus.proc_stop = 1'b1;
            if (c == 9) begin
                bus.proc_stop = 1'b0;
                chk("t3_beat_cnt_hold", 32'(bus.beat_cnt), 6);
            end
        end
        wait_done("t3_done");
        chk("t3_beat_cnt", 32'(bus.beat_cnt), 6);
        chk("t3_tx_nrx_idle", 32'(bus.tx_nrx), 0);

        // 4: TX underrun at the 6th beat, then boundary coinciding with last beat
        start_burst(1'b1, 16'd16);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick();
            if (c == 8) bus.rempty = 1'b1;
        end
        chk("t4_err", 32'(bus.err), 1);
        chk("t4_beat_cnt", 32'(bus.beat_cnt), 5);
        chk("t4_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("t4_jesd_en", 32'(bus.jesd_en), 32'(exp_en(9, 3, 8)));
        chk("t4_busy", 32'(bus.busy), 1);
        bus.rempty = 1'b0;
        wait_done("t4_done");
        chk("t4_err_sticky", 32'(bus.err), 1);
        start_burst(1'b1, 16'd2);
        chk("t4_err_clear", 32'(bus.err), 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 4) bus.rempty = 1'b1;
        end
        chk("t4_last_err", 32'(bus.err), 0);
        chk("t4_last_beat_cnt", 32'(bus.beat_cnt), 2);
        bus.rempty = 1'b0;
        wait_done("t4_last_done");

        // stop during SETUP: straight to GUARD, ENABLE never asserts
        start_burst(1'b1, 16'd4);
        bus.proc_stop = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            tick();
            bus.proc_stop = 1'b0;
            chk("ts_jesd_en", 32'(bus.jesd_en), 0);
            chk("ts_done", 32'(bus.done), 32'(c == 6));
            chk("ts_busy", 32'(bus.busy), 32'(c <= 5));
        end

        // 5: reset mid-ACTIVE, then start requests during HOLD/GUARD ignored
        start_burst(1'b1, 16'd8);
        for (int c = 2; c <= 5; c++) tick();
        chk("t5_rd_active", 32'(bus.fifo_rd_en), 1);
        rstn = 1'b0;
        tick();
        chk("t5_rst_tx_nrx", 32'(bus.tx_nrx), 0);
        chk("t5_rst_jesd_en", 32'(bus.jesd_en), 0);
        chk("t5_rst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_beat_cnt", 32'(bus.beat_cnt), 0);
        rstn = 1'b1;
        tick();
        start_burst(1'b1, 16'd2);
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            bus.proc_start = 1'b0;
            chk("t5_tx_nrx", 32'(bus.tx_nrx), 1);
            chk("t5_rd_en", 32'(bus.fifo_rd_en), 32'(c >= 3 && c <= 4));
            chk("t5_busy", 32'(bus.busy), 32'(c <= 10));
            chk("t5_done", 32'(bus.done), 32'(c == 11));
            if (c == 5 || c == 10) begin
                bus.btn_tx_nrx = 1'b0;
                bus.burst_len  = 16'd9;
                bus.proc_start = 1'b1;
            end
        end
        chk("t5_beat_cnt", 32'(bus.beat_cnt), 2);
        tick();
        chk("t5_idle_busy", 32'(bus.busy), 0);
        chk("t5_idle_tx_nrx", 32'(bus.tx_nrx), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
